uart_alu_intf: RTL and testbench
================================

UART_ALU_INTF -- requirements
Module: uart_alu_intf

Interface
REQ-001 Parameter DBIT, default 8, SHALL set the data width of operands, result and serial bytes.
REQ-002 Parameter NB_OP, default 6, SHALL set the opcode width, taken from rx_data[NB_OP-1:0].
REQ-003 Parameter TO_CYCLES, default 1000000, SHALL set the inter-byte timeout in clk cycles; timeout counter 20 bits wide.
REQ-004 Port clk, input, 1: single clock; all logic SHALL sample on posedge clk.
REQ-005 Port reset, input, 1: reset is synchronous and active-high.
REQ-006 Port rx_done_tick, input, 1: one-cycle pulse from the UART receiver marking a valid byte.
REQ-007 Port rx_data, input, DBIT: received byte, valid when rx_done_tick=1.
REQ-008 Port tx_done_tick, input, 1: one-cycle pulse from the UART transmitter marking end of stop bit.
REQ-009 Port tx_start, output, 1: one-cycle request to the transmitter.
REQ-010 Port tx_data, output, DBIT: registered ALU result byte for the transmitter.
REQ-011 Port busy, output, 1: high in SEND and WAIT_TX.
REQ-012 Port ovr_tick, output, 1: one-cycle pulse when an rx byte is dropped.
REQ-013 Port to_tick, output, 1: one-cycle pulse when a partial frame is abandoned on timeout.

Function
REQ-014 FSM states SHALL be WAIT_A, WAIT_B, WAIT_OP, SEND, WAIT_TX.
REQ-015 WAIT_A + rx_done_tick: latch A=rx_data, go WAIT_B.
REQ-016 WAIT_B + rx_done_tick: latch B=rx_data, go WAIT_OP.
REQ-017 WAIT_OP + rx_done_tick: latch opcode, compute result, register it into tx_data, go SEND, all in the same edge.
REQ-018 SEND: tx_start=1 for exactly one cycle, then WAIT_TX unconditionally.
REQ-019 WAIT_TX + tx_done_tick: go WAIT_A; otherwise stay, with no timeout.
REQ-020 Opcodes (6-bit): 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x03 SRA (A>>>B), 0x02 SRL (A>>B).
REQ-021 ADD/SUB SHALL be modulo 2^DBIT with carry/borrow discarded.
REQ-022 Shift amount SHALL be B, unsigned, full width; B>=DBIT gives full sign fill (SRA) or zero (SRL).
REQ-023 Any other opcode SHALL produce result 0x00, and the result SHALL still be transmitted.
REQ-024 rx_done_tick in SEND or WAIT_TX: byte discarded, ovr_tick=1 the next cycle, no state change.
REQ-025 tx_data SHALL hold its value from SEND until the next WAIT_OP acceptance.
REQ-026 Timeout counter SHALL clear on every accepted byte and whenever the state is WAIT_A, SEND or WAIT_TX.
REQ-027 Timeout counter SHALL increment every cycle in WAIT_B and WAIT_OP.
REQ-028 When the counter reaches TO_CYCLES-1 with no rx_done_tick in that cycle: go WAIT_A, pulse to_tick, discard A/B.
REQ-029 If rx_done_tick coincides with the timeout cycle, the byte SHALL be accepted and no timeout SHALL occur.
REQ-030 tx_done_tick outside WAIT_TX SHALL be ignored.
REQ-031 Latency from the opcode rx_done_tick to tx_start SHALL be exactly 1 cycle.

Reset
REQ-032 Reset SHALL force state WAIT_A, A=B=opcode=0, tx_data=0x00, tx_start=0, busy=0, ovr_tick=0, to_tick=0, timeout counter=0.
REQ-033 Reset mid-frame or in WAIT_TX SHALL abandon the frame; no tx_start follows.
REQ-034 Reset SHALL take priority over rx_done_tick and tx_done_tick in the same cycle.

Verification
REQ-035 Bytes 0x05, 0x03, 0x20 -> tx_data=0x08, one tx_start pulse 1 cycle after the third tick, busy=1 until tx_done_tick.
REQ-036 Bytes 0x03, 0x05, 0x22 -> 0xFE; bytes 0x80, 0x01, 0x03 -> 0xC0; bytes 0x80, 0x09, 0x02 -> 0x00; bytes 0xF0, 0x0F, 0x27 -> 0x00.
REQ-037 Bytes 0x12, 0x34, 0x3F (invalid) -> tx_data=0x00, tx_start still pulses.
REQ-038 TO_CYCLES=16, send 0x11, then idle 16 cycles -> to_tick pulse, state WAIT_A; next 0x01, 0x01, 0x20 -> 0x02.
REQ-039 Extra rx_done_tick in WAIT_TX -> ovr_tick pulse, tx_data unchanged, next frame correct.
REQ-040 Reset asserted after A and B, then 0x20 sent -> no tx_start; the 0x20 byte is taken as the new A.

Source files
------------

// File: rtl/uart_alu_intf.sv
// Collects operand A, operand B and an opcode byte from a UART receiver, then sends one ALU result byte.
// Latency: 1 cycle from the opcode rx_done_tick to tx_start; bytes arriving while busy are dropped and flagged on ovr_tick.
module uart_alu_intf #(
  parameter int DBIT      = 8,
  parameter int NB_OP     = 6,
  parameter int TO_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_done_tick,
  input  logic [DBIT-1:0] rx_data,
  input  logic            tx_done_tick,
  output logic            tx_start,
  output logic [DBIT-1:0] tx_data,
  output logic            busy,
  output logic            ovr_tick,
  output logic            to_tick
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    SEND,
    WAIT_TX
  } state_t;

  localparam logic [19:0]      TO_LAST = 20'(TO_CYCLES - 1);
  localparam logic [NB_OP-1:0] OP_ADD  = NB_OP'(6'h20);
  localparam logic [NB_OP-1:0] OP_SUB  = NB_OP'(6'h22);
  localparam logic [NB_OP-1:0] OP_AND  = NB_OP'(6'h24);
  localparam logic [NB_OP-1:0] OP_OR   = NB_OP'(6'h25);
  localparam logic [NB_OP-1:0] OP_XOR  = NB_OP'(6'h26);
  localparam logic [NB_OP-1:0] OP_NOR  = NB_OP'(6'h27);
  localparam logic [NB_OP-1:0] OP_SRA  = NB_OP'(6'h03);
  localparam logic [NB_OP-1:0] OP_SRL  = NB_OP'(6'h02);

  state_t            state, state_next;
  logic [DBIT-1:0]   a_reg, b_reg;
  logic [NB_OP-1:0]  op_reg, op_next;
  logic [19:0]       to_cnt;
  logic              accept, timeout, drop;

  // Shift amount is the whole B byte, so B >= DBIT saturates to sign/zero fill.
  function automatic logic [DBIT-1:0] alu(input logic [DBIT-1:0] a,
                                          input logic [DBIT-1:0] b,
                                          input logic [NB_OP-1:0] op);
    logic [DBIT-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SRA:  r = $signed(a) >>> b;
      OP_SRL:  r = a >> b;
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    timeout    = 1'b0;
    drop       = 1'b0;
    case (state)
      WAIT_A: begin
        if (rx_done_tick) begin
          accept     = 1'b1;
          state_next = WAIT_B;
        end
      end
      WAIT_B: begin
        if (rx_done_tick) begin
          accept     = 1'b1;
          state_next = WAIT_OP;
        end else if (to_cnt == TO_LAST) begin
          timeout    = 1'b1;
          state_next = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (rx_done_tick) begin
          accept     = 1'b1;
          state_next = SEND;
        end else if (to_cnt == TO_LAST) begin
          timeout    = 1'b1;
          state_next = WAIT_A;
        end
      end
      SEND: begin
        drop       = rx_done_tick;
        state_next = WAIT_TX;
      end
      WAIT_TX: begin
        drop = rx_done_tick;
        if (tx_done_tick) state_next = WAIT_A;
      end
      default: state_next = WAIT_A;
    endcase
  end

  assign op_next  = (state == WAIT_OP && rx_done_tick) ? rx_data[NB_OP-1:0] : op_reg;
  assign tx_start = (state == SEND);
  assign busy     = (state == SEND) || (state == WAIT_TX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WAIT_A;
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= '0;
      tx_data  <= '0;
      ovr_tick <= 1'b0;
      to_tick  <= 1'b0;
      to_cnt   <= '0;
    end else begin
      state    <= state_next;
      ovr_tick <= drop;
      to_tick  <= timeout;
      if (accept && state == WAIT_A) a_reg <= rx_data;
      if (accept && state == WAIT_B) b_reg <= rx_data;
      if (accept && state == WAIT_OP) begin
        op_reg  <= op_next;
        tx_data <= alu(a_reg, b_reg, op_next);
      end
      if (timeout) begin
        a_reg <= '0;
        b_reg <= '0;
      end
      // Counter only runs while a frame is partially collected.
      if (accept || timeout || state == WAIT_A || state == SEND || state == WAIT_TX)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 20'd1;
    end
  end

endmodule

// File: tb/tb_uart_alu_intf.sv
// Randomized and directed bench for uart_alu_intf against a frame-level reference model.
module tb_uart_alu_intf;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_done_tick = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       ovr_tick;
  logic       to_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_alu_intf #(.DBIT(8), .NB_OP(6), .TO_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .tx_done_tick(tx_done_tick), .tx_start(tx_start), .tx_data(tx_data),
    .busy(busy), .ovr_tick(ovr_tick), .to_tick(to_tick)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    int ia, ib, r, v;
    ia = int'(a);
    ib = int'(b);
    r  = 0;
    case (op)
      6'h20: r = (ia + ib) % 256;
      6'h22: r = (ia - ib + 256) % 256;
      6'h24: r = ia & ib;
      6'h25: r = ia | ib;
      6'h26: r = ia ^ ib;
      6'h27: r = 255 - (ia | ib);
      6'h03: begin
        v = (ia >= 128) ? ia - 256 : ia;
        for (int k = 0; k < ib && k < 8; k++) v = (v < 0) ? (v - 1) / 2 : v / 2;
        r = (v + 256) % 256;
      end
      6'h02: r = (ib >= 8) ? 0 : ia / (1 << ib);
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  // Reference model: frame-level view (bytes collected, transmission in flight, idle time).
  int         m_cnt = 0;
  int         m_idle = 0;
  logic [7:0] m_a = 8'h00, m_b = 8'h00, m_txd = 8'h00;
  bit         m_tx = 0, m_first = 0, m_ovr = 0, m_to = 0, m_valid = 0;

  always @(posedge clk) begin : model
    int c, idle;
    logic [7:0] a, b, txd;
    bit tx, first, ovr, tmo;
    c = m_cnt; idle = m_idle; a = m_a; b = m_b; txd = m_txd;
    tx = m_tx; first = m_first; ovr = 0; tmo = 0;
    if (reset) begin
      c = 0; idle = 0; a = 0; b = 0; txd = 0; tx = 0; first = 0;
    end else if (tx) begin
      if (rx_done_tick) ovr = 1;
      if (first) first = 0;
      else if (tx_done_tick) tx = 0;
    end else if (rx_done_tick) begin
      idle = 0;
      if (c == 0) begin a = rx_data; c = 1; end
      else if (c == 1) begin b = rx_data; c = 2; end
      else begin txd = ref_alu(a, b, rx_data[5:0]); tx = 1; first = 1; c = 0; end
    end else if (c > 0) begin
      if (idle == TO - 1) begin c = 0; idle = 0; tmo = 1; a = 0; b = 0; end
      else idle++;
    end
    m_cnt <= c; m_idle <= idle; m_a <= a; m_b <= b; m_txd <= txd;
    m_tx <= tx; m_first <= first; m_ovr <= ovr; m_to <= tmo;
    m_valid <= m_valid | reset;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_tx_start", {7'd0, tx_start}, {7'd0, m_tx & m_first});
      chk("cyc_busy", {7'd0, busy}, {7'd0, m_tx});
      chk("cyc_ovr_tick", {7'd0, ovr_tick}, {7'd0, m_ovr});
      chk("cyc_to_tick", {7'd0, to_tick}, {7'd0, m_to});
      chk("cyc_tx_data", tx_data, m_txd);
    end
  end

  task automatic cyc(input bit rxt, input logic [7:0] d, input bit txt, input bit rst);
    rx_done_tick = rxt;
    rx_data      = d;
    tx_done_tick = txt;
    reset        = rst;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                       input logic [7:0] exp, input string nm);
    send(a);
    send(b);
    send(op);
    chk({nm, "_start"}, {7'd0, tx_start}, 8'd1);
    chk({nm, "_data"}, tx_data, exp);
    idle(3);
    chk({nm, "_busy"}, {7'd0, busy}, 8'd1);
    chk({nm, "_nostart"}, {7'd0, tx_start}, 8'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk({nm, "_idle"}, {7'd0, busy}, 8'd0);
  endtask

  logic [7:0] ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

  initial begin
    logic [7:0] d;
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h77, 1'b1, 1'b1);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_tx_start", {7'd0, tx_start}, 8'd0);
    chk("rst_ovr", {7'd0, ovr_tick}, 8'd0);
    chk("rst_to", {7'd0, to_tick}, 8'd0);

    frame(8'h05, 8'h03, 8'h20, 8'h08, "add");
    frame(8'h03, 8'h05, 8'h22, 8'hFE, "sub");
    frame(8'h80, 8'h01, 8'h03, 8'hC0, "sra");
    frame(8'h80, 8'h09, 8'h02, 8'h00, "srl");
    frame(8'hF0, 8'h0F, 8'h27, 8'h00, "nor");
    frame(8'h12, 8'h34, 8'h3F, 8'h00, "inv");
    frame(8'h81, 8'h0A, 8'h03, 8'hFF, "sra_wide");

    // Timeout boundary from WAIT_B, then recovery
    send(8'h11);
    idle(TO - 1);
    chk("to_early", {7'd0, to_tick}, 8'd0);
    idle(1);
    chk("to_tick", {7'd0, to_tick}, 8'd1);
    frame(8'h01, 8'h01, 8'h20, 8'h02, "after_to");

    // Byte arriving on the timeout cycle is accepted
    send(8'h11);
    idle(TO - 1);
    send(8'h22);
    chk("to_coincide", {7'd0, to_tick}, 8'd0);
    send(8'h20);
    chk("coincide_start", {7'd0, tx_start}, 8'd1);
    chk("coincide_data", tx_data, 8'h33);
    idle(1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Overrun while waiting on the transmitter
    send(8'h0A); send(8'h05); send(8'h26);
    idle(2);
    cyc(1'b1, 8'h99, 1'b0, 1'b0);
    chk("ovr_tick", {7'd0, ovr_tick}, 8'd1);
    chk("ovr_data", tx_data, 8'h0F);
    idle(1);
    chk("ovr_clear", {7'd0, ovr_tick}, 8'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    frame(8'h07, 8'h02, 8'h02, 8'h01, "after_ovr");

    // Reset after A and B: the opcode byte becomes the new A
    send(8'h40); send(8'h41);
    cyc(1'b1, 8'h55, 1'b1, 1'b1);
    chk("midrst_data", tx_data, 8'h00);
    send(8'h20);
    chk("midrst_nostart", {7'd0, tx_start}, 8'd0);
    chk("midrst_busy", {7'd0, busy}, 8'd0);
    send(8'h03); send(8'h20);
    chk("midrst_start", {7'd0, tx_start}, 8'd1);
    chk("midrst_result", tx_data, 8'h23);
    idle(1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset while in WAIT_TX
    send(8'h01); send(8'h02); send(8'h20);
    idle(1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("txrst_busy", {7'd0, busy}, 8'd0);
    idle(2);
    chk("txrst_nostart", {7'd0, tx_start}, 8'd0);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        idle($urandom_range(10, 20));
      end else begin
        d = ($urandom_range(0, 1) == 1) ? ops[$urandom_range(0, 7)] : 8'($urandom);
        cyc($urandom_range(0, 99) < 35, d, $urandom_range(0, 99) < 20,
            $urandom_range(0, 399) == 0);
      end
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
